// File: rtl/mat_io_pkg.sv
// Shared definitions for the matrix I/O controller: state encoding, element
// geometry and the row-major packing offset used for A/B/C flat buses.
package mat_io_pkg;

  localparam int unsigned N_ELEM = 9;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned FLAT_W = N_ELEM * ELEM_W;
  localparam int unsigned OFF_W  = $clog2(FLAT_W);
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [2:0] {
    S_FILL,
    S_LOAD,
    S_WAIT_LO,
    S_WAIT_HI,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  // Bit offset of element i (i = 3*row + col) inside a flat 3x3 bus.
  function automatic logic [OFF_W-1:0] elem_off(input logic [3:0] i);
    return OFF_W'(i) * OFF_W'(ELEM_W);
  endfunction

endpackage

// File: rtl/mat_io_wdog.sv
// Timeout watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT.
module mat_io_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Asserted during the TIMEOUT-th enabled cycle so the abort lands on the
  // same edge that would bring the count to TIMEOUT.
  assign expired = en && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mat_io_ctrl.sv
// Streams 18 operand bytes into A/B, launches the 3x3 multiplier, waits for
// completion (with timeout) and streams the 9 result bytes back out.
module mat_io_ctrl
  import mat_io_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output logic              in_ready,
  output logic [FLAT_W-1:0] A_flat,
  output logic [FLAT_W-1:0] B_flat,
  output logic              mat_load,
  input  logic              mat_done,
  input  logic [FLAT_W-1:0] C_flat,
  output logic              out_valid,
  output logic [ELEM_W-1:0] out_data,
  input  logic              out_ready,
  output logic              err
);

  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(2 * N_ELEM - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(N_ELEM - 1);
  localparam logic [IDX_W-1:0] IDX_B0   = IDX_W'(N_ELEM);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [FLAT_W-1:0] r_a;
  logic [FLAT_W-1:0] r_b;
  logic [FLAT_W-1:0] r_res;
  logic              r_in_ready;
  logic              r_mat_load;
  logic              r_out_valid;
  logic              r_err;

  logic              w_clr;
  logic              w_en;
  logic              w_expired;
  logic [3:0]        w_b_sel;

  assign w_clr   = (r_state == S_LOAD);
  assign w_en    = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  assign w_b_sel = 4'(r_idx - IDX_B0);

  mat_io_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .Reset_n (Reset_n),
    .clr     (w_clr),
    .en      (w_en),
    .expired (w_expired)
  );

  assign in_ready  = r_in_ready;
  assign mat_load  = r_mat_load;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign A_flat    = r_a;
  assign B_flat    = r_b;
  assign out_data  = r_out_valid ? r_res[elem_off(r_idx[3:0]) +: ELEM_W] : '0;

  // Handshake flags are registered alongside the state so they read 0 while
  // reset is held and only come up on the first clock after release.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b0;
      r_mat_load  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_expired) begin
      r_err      <= 1'b1;
      r_state    <= S_FILL;
      r_idx      <= '0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_FILL: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            if (r_idx < IDX_B0) begin
              r_a[elem_off(r_idx[3:0]) +: ELEM_W] <= in_data;
            end else begin
              r_b[elem_off(w_b_sel) +: ELEM_W] <= in_data;
            end
            if (r_idx == LAST_IN) begin
              r_idx      <= '0;
              r_state    <= S_LOAD;
              r_in_ready <= 1'b0;
              r_mat_load <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_LOAD: begin
          r_mat_load <= 1'b0;
          r_state    <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!mat_done) r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (mat_done) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_res       <= C_flat;
          r_state     <= S_DRAIN;
          r_out_valid <= 1'b1;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_idx == LAST_OUT) begin
              r_idx       <= '0;
              r_state     <= S_FILL;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state     <= S_FILL;
          r_idx       <= '0;
          r_mat_load  <= 1'b0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_io_ctrl.sv
// Scoreboard bench for mat_io_ctrl with a behavioural 3x3 multiplier model.
module tb_mat_io_ctrl;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [71:0] A_flat;
  logic [71:0] B_flat;
  logic        mat_load;
  logic        mat_done = 1'b1;
  logic [71:0] C_flat = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        err;

  always #5 clk = ~clk;

  mat_io_ctrl #(.TIMEOUT(255)) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .A_flat    (A_flat),
    .B_flat    (B_flat),
    .mat_load  (mat_load),
    .mat_done  (mat_done),
    .C_flat    (C_flat),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pops    = 0;
  int         n_load  = 0;
  logic [7:0] sb_q[$];
  bit         mul_stuck = 1'b0;
  int         mul_lo    = 2;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] pack(input logic [7:0] m[9]);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[8*i +: 8] = m[i];
    return r;
  endfunction

  function automatic logic [71:0] matmul(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] c;
    logic [7:0]  s;
    c = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = '0;
        for (int k = 0; k < 3; k++) s = s + 8'(a[8*(3*i+k) +: 8] * b[8*(3*k+j) +: 8]);
        c[8*(3*i+j) +: 8] = s;
      end
    return c;
  endfunction

  // Monitor: pops the scoreboard on every output handshake, checks stall hold.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (mat_load) n_load++;
      if (Reset_n) begin
        if (prev_stall) begin
          chk("hold_valid", 72'(out_valid), 72'(1'b1));
          chk("hold_data", 72'(out_data), 72'(prev_data));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected no output", out_data);
          end else begin
            exp = sb_q.pop_front();
            chk("out_byte", 72'(out_data), 72'(exp));
          end
          pops++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Multiplier model: drops mat_done after a load, computes C, raises mat_done.
  initial begin
    forever begin
      step();
      if (mat_load && !mul_stuck) begin
        step();
        mat_done = 1'b0;
        C_flat   = matmul(A_flat, B_flat);
        repeat (mul_lo) step();
        mat_done = 1'b1;
        step();
        chk("lat_capture", 72'(out_valid), 72'(1'b0));
        step();
        chk("lat_first_out", 72'(out_valid), 72'(1'b1));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 72'(in_ready), 72'(1'b1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_mats(input logic [7:0] a[9], input logic [7:0] b[9], input bit gap);
    for (int i = 0; i < 18; i++) begin
      send_byte(i < 9 ? a[i] : b[i-9]);
      if (gap && i < 17) step();
    end
    chk("load_pulse", 72'(mat_load), 72'(1'b1));
    chk("in_ready_load", 72'(in_ready), 72'(1'b0));
    chk("A_flat", A_flat, pack(a));
    chk("B_flat", B_flat, pack(b));
  endtask

  task automatic push_exp(input logic [7:0] e[9], input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(e[i]);
  endtask

  task automatic wait_pops(input int target);
    int t;
    t = 0;
    while (pops < target && t < 400) begin
      step();
      t++;
    end
    chk("wait_pops", 72'(pops), 72'(target));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 400) begin
      step();
      t++;
    end
    repeat (3) step();
    chk("drain_empty", 72'(sb_q.size()), 72'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] a[9];
    logic [7:0] b[9];
    logic [7:0] e[9];
    int n0;
    int p0;

    repeat (3) step();
    chk("rst_in_ready", 72'(in_ready), 72'(1'b0));
    chk("rst_mat_load", 72'(mat_load), 72'(1'b0));
    chk("rst_out_valid", 72'(out_valid), 72'(1'b0));
    chk("rst_out_data", 72'(out_data), 72'(8'h00));
    chk("rst_err", 72'(err), 72'(1'b0));
    chk("rst_A", A_flat, 72'(0));
    Reset_n = 1'b1;
    step();
    step();
    chk("post_rst_in_ready", 72'(in_ready), 72'(1'b1));

    // Identity times 1..9, no gaps.
    n0 = n_load;
    a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    e = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    push_exp(e, 9);
    send_mats(a, b, 1'b0);
    wait_drain();
    chk("t1_load_count", 72'(n_load - n0), 72'(1));
    chk("t1_err", 72'(err), 72'(1'b0));

    // All 2 times all 3, in_valid toggling.
    a = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    b = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    e = '{18, 18, 18, 18, 18, 18, 18, 18, 18};
    push_exp(e, 9);
    send_mats(a, b, 1'b1);
    wait_drain();

    // Output stall of 5 cycles at byte 4.
    a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    b = '{20, 21, 22, 23, 24, 25, 26, 27, 28};
    e = '{20, 21, 22, 23, 24, 25, 26, 27, 28};
    p0 = pops;
    push_exp(e, 9);
    send_mats(a, b, 1'b0);
    wait_pops(p0 + 4);
    out_ready = 1'b0;
    repeat (5) begin
      step();
      chk("stall_valid", 72'(out_valid), 72'(1'b1));
      chk("stall_data", 72'(out_data), 72'(8'd24));
    end
    chk("stall_no_skip", 72'(pops - p0), 72'(4));
    out_ready = 1'b1;
    wait_drain();

    // Multiplier never drops mat_done: timeout after 255 wait cycles.
    mul_stuck = 1'b1;
    n0 = n_load;
    a = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    b = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    send_mats(a, b, 1'b0);
    for (int k = 1; k <= 256; k++) begin
      step();
      if (k == 255) chk("to_err_before", 72'(err), 72'(1'b0));
      if (k == 256) begin
        chk("to_err_set", 72'(err), 72'(1'b1));
        chk("to_back_fill", 72'(in_ready), 72'(1'b1));
      end
    end
    mul_stuck = 1'b0;
    repeat (5) step();
    chk("to_load_count", 72'(n_load - n0), 72'(1));

    // in_valid held during WAIT_HI is ignored; err stays sticky.
    mul_lo = 12;
    n0 = n_load;
    a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    b = '{2, 0, 0, 0, 2, 0, 0, 0, 2};
    e = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
    push_exp(e, 9);
    send_mats(a, b, 1'b0);
    repeat (4) step();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (4) begin
      step();
      chk("wh_in_ready", 72'(in_ready), 72'(1'b0));
      chk("wh_A", A_flat, pack(a));
      chk("wh_B", B_flat, pack(b));
    end
    in_valid = 1'b0;
    wait_drain();
    chk("wh_err_sticky", 72'(err), 72'(1'b1));
    chk("wh_load_count", 72'(n_load - n0), 72'(1));
    mul_lo = 2;

    // Reset pulse while byte 3 is being presented.
    a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    b = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
    e = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
    p0 = pops;
    push_exp(e, 3);
    send_mats(a, b, 1'b0);
    wait_pops(p0 + 3);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 72'(out_valid), 72'(1'b0));
    chk("mid_rst_out_data", 72'(out_data), 72'(8'h00));
    chk("mid_rst_in_ready", 72'(in_ready), 72'(1'b0));
    chk("mid_rst_err", 72'(err), 72'(1'b0));
    chk("mid_rst_B", B_flat, 72'(0));
    step();
    step();
    Reset_n = 1'b1;
    step();
    step();
    chk("mid_rst_release_ready", 72'(in_ready), 72'(1'b1));
    repeat (20) step();
    chk("mid_rst_no_out", 72'(pops - p0), 72'(3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_io_ctrl.md
MAT_IO_CTRL -- requirements
Module: mat_io_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles spent in WAIT_LO plus WAIT_HI before abort.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operand byte valid.
REQ-005 SHALL have port in_data, input, 8 bits: operand byte.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operand byte.
REQ-007 SHALL have port A_flat, output, 72 bits: element Aij at bits [8*(3i+j)+7 : 8*(3i+j)].
REQ-008 SHALL have port B_flat, output, 72 bits: same packing as A_flat.
REQ-009 SHALL have port mat_load, output, 1 bit: start pulse to the multiplier.
REQ-010 SHALL have port mat_done, input, 1 bit: multiplier idle/complete flag, high when idle.
REQ-011 SHALL have port C_flat, input, 72 bits: multiplier products, same packing.
REQ-012 SHALL have port out_valid, output, 1 bit: result byte valid.
REQ-013 SHALL have port out_data, output, 8 bits: result byte.
REQ-014 SHALL have port out_ready, input, 1 bit: sink accepts a result byte.
REQ-015 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-016 SHALL implement states FILL, LOAD, WAIT_LO, WAIT_HI, CAPTURE, DRAIN, with a 5-bit index idx.
REQ-017 FILL: in_ready=1; byte accepted when in_valid&&in_ready; bytes 0-8 go to A and bytes 9-17 go to B, both row-major; idx increments per accept; the accept at idx=17 goes to LOAD with idx=0.
REQ-018 LOAD: mat_load=1 for exactly one cycle, then WAIT_LO; mat_load=0 in every other state.
REQ-019 WAIT_LO: mat_done=0 moves to WAIT_HI; otherwise stay.
REQ-020 WAIT_HI: mat_done=1 moves to CAPTURE; otherwise stay.
REQ-021 A_flat and B_flat SHALL hold stable from the last FILL accept until the next FILL accept.
REQ-022 Timeout counter: cleared in LOAD, incremented each cycle in WAIT_LO/WAIT_HI; reaching TIMEOUT sets err=1, goes to FILL with idx=0, and discards the operands' result.
REQ-023 CAPTURE: registers C_flat into a 72-bit result buffer in one cycle, then DRAIN.
REQ-024 DRAIN: out_valid=1 and out_data=result element idx (row-major); idx increments on out_valid&&out_ready; the accept at idx=8 goes to FILL with idx=0.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 in_ready=0 outside FILL; in_valid in other states is ignored and no data is lost or counted.
REQ-027 Latency: mat_load is asserted the cycle after the 18th accept; the first out_valid is 2 cycles after mat_done rises in WAIT_HI.
REQ-028 err SHALL clear only on reset; a timeout does not stop subsequent operation.
REQ-029 Data SHALL pass through unmodified, 8-bit, with no arithmetic in this block.

Reset
REQ-030 Reset_n=0 SHALL asynchronously force state=FILL, idx=0, timeout counter=0, A/B/result buffers=0, and err=0.
REQ-031 While Reset_n=0: in_ready=0, mat_load=0, out_valid=0, out_data=0.
REQ-032 Reset asserted in any state, including mid-DRAIN or WAIT_HI, SHALL abandon the transaction with no partial output after release.

Structure
REQ-033 A shared package mat_io_pkg SHALL hold the state encoding, N_ELEM=9, ELEM_W=8, and the packing offset function.
REQ-034 The timeout counter SHALL be a sub-module mat_io_wdog with ports clk, Reset_n, clr, en, and expired.
REQ-035 Total RTL SHALL be under 400 lines, with a behavioural multiplier model in the bench only.

Verification
REQ-036 A=identity, B=1..9 streamed with no gaps -> mat_load pulses once; out bytes are 1,2,...,9 in order; err=0.
REQ-037 A=all 2, B=all 3 with in_valid toggling every other cycle -> 18 accepts counted correctly; out bytes are nine 18s.
REQ-038 out_ready low for 5 cycles at byte 4 -> out_data holds at byte 4 and out_valid stays 1; no byte is duplicated or skipped.
REQ-039 mat_done held at 1 after LOAD with TIMEOUT=255 -> err=1 at cycle 255 after LOAD; state returns to FILL; no out_valid.
REQ-040 Reset_n pulsed low at DRAIN byte 3 -> outputs reach reset values immediately; after release, in_ready=1 and no further out_valid.
REQ-041 in_valid=1 during WAIT_HI -> in_ready=0 and A_flat/B_flat are unchanged.
